// File: rtl/debug_mem_stepper.sv
// debug_mem_stepper: pushbutton/auto stepper that reads butterfly address pairs (A, A+MEM_SIZE/2)
// from a latency-RD_LATENCY memory and holds the captured words for display.
module debug_mem_stepper #(
   parameter int WORD_SIZE       = 16,
   parameter int MEM_SIZE        = 32,
   parameter int ADDR_SIZE       = $clog2(MEM_SIZE),
   parameter int RD_LATENCY      = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_DWELL      = 64
) (
   input  logic                 i_CLK,
   input  logic                 i_RST_n,
   input  logic                 i_step_n,
   input  logic                 i_auto,
   input  logic [WORD_SIZE-1:0] i_rddata_A,
   input  logic [WORD_SIZE-1:0] i_rddata_B,
   output logic [ADDR_SIZE-1:0] o_rdaddr_A,
   output logic [ADDR_SIZE-1:0] o_rdaddr_B,
   output logic                 o_rden,
   output logic [WORD_SIZE-1:0] o_capdata_A,
   output logic [WORD_SIZE-1:0] o_capdata_B,
   output logic                 o_memval,
   output logic [3:0]           o_STATE,
   output logic                 o_busy
);
   typedef enum logic [3:0] {IDLE = 4'h0, REQ = 4'h1, WAIT = 4'h2, CAPTURE = 4'h3, SHOW = 4'h4} state_t;
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DWW = $clog2(AUTO_DWELL + 1);
   localparam int LW  = $clog2(RD_LATENCY + 1);
   localparam logic [ADDR_SIZE-1:0] HALF = ADDR_SIZE'(MEM_SIZE / 2);
   localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_SIZE / 2 - 1);
   state_t state, state_nx;
   logic [1:0] sync;
   logic acc, step;
   logic [DBW-1:0] db_cnt;
   logic [DWW-1:0] dwell;
   logic [LW-1:0] wcnt;
   logic [ADDR_SIZE-1:0] addr;
   logic dwell_done, advance;
   // step fires once, on the edge where the accepted level falls from high to low
   always_ff @(posedge i_CLK or negedge i_RST_n)
      if (!i_RST_n) begin
         sync   <= 2'b11;
         acc    <= 1'b1;
         db_cnt <= '0;
         step   <= 1'b0;
      end else begin
         sync <= {sync[0], i_step_n};
         step <= 1'b0;
         if (sync[1] == acc) db_cnt <= '0;
         else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            acc    <= sync[1];
            db_cnt <= '0;
            step   <= acc;
         end else db_cnt <= db_cnt + 1'b1;
      end
   assign dwell_done = dwell == DWW'(AUTO_DWELL - 1);
   assign advance    = (state == SHOW) && (step || (i_auto && dwell_done));
   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = step ? REQ : IDLE;
         REQ:     state_nx = (RD_LATENCY > 1) ? WAIT : CAPTURE;
         WAIT:    state_nx = (wcnt == LW'(RD_LATENCY - 2)) ? CAPTURE : WAIT;
         CAPTURE: state_nx = SHOW;
         SHOW:    state_nx = advance ? REQ : SHOW;
         default: state_nx = IDLE;
      endcase
   end
   // dwell saturates so a late i_auto still advances at once; it clears outside SHOW
   always_ff @(posedge i_CLK or negedge i_RST_n)
      if (!i_RST_n) begin
         state       <= IDLE;
         addr        <= '0;
         wcnt        <= '0;
         dwell       <= '0;
         o_capdata_A <= '0;
         o_capdata_B <= '0;
      end else begin
         state <= state_nx;
         wcnt  <= (state == WAIT) ? wcnt + 1'b1 : '0;
         dwell <= (state != SHOW) ? '0 : dwell_done ? dwell : dwell + 1'b1;
         if (advance) addr <= (addr == LAST) ? '0 : addr + 1'b1;
         if (state == CAPTURE) begin
            o_capdata_A <= i_rddata_A;
            o_capdata_B <= i_rddata_B;
         end
      end
   assign o_rdaddr_A = addr;
   assign o_rdaddr_B = addr + HALF;
   assign o_rden     = state == REQ;
   assign o_memval   = state == SHOW;
   assign o_busy     = (state != IDLE) && (state != SHOW);
   assign o_STATE    = state;
endmodule

// File: tb/tb_debug_mem_stepper.sv
// tb_debug_mem_stepper: randomized presses/auto-advance against a queue-based model of the
// stepper, backed by a latency-RDL memory that drives junk whenever its data is not valid.
module tb_debug_mem_stepper;
   localparam int RDL = 2;
   logic clk = 1'b0, rst_n = 1'b0, step_n = 1'b1, auto_en = 1'b0;
   logic [15:0] rda, rdb, capa, capb, junk_a, junk_b;
   logic [4:0] ra, rb;
   logic rden, memval, busy;
   logic [3:0] st;
   logic [15:0] mem [32];
   logic pv [RDL] = '{default: 1'b0};
   logic [4:0] pa [RDL], pb [RDL];
   int checks = 0, errors = 0, cyc = 0, rden_cyc = 0, show_cnt = 0, a_m = 0;
   bit mon_en = 0, from_idle = 1;
   logic [3:0] prev_st = 4'h0;
   logic [31:0] prev_cap = '0;
   logic [9:0] rq [$];
   int sq [$], lq [$];
   logic [31:0] cq [$];

   debug_mem_stepper #(.WORD_SIZE(16), .MEM_SIZE(32), .RD_LATENCY(RDL), .DEBOUNCE_CYCLES(4),
                       .AUTO_DWELL(8)) dut (
      .i_CLK(clk), .i_RST_n(rst_n), .i_step_n(step_n), .i_auto(auto_en),
      .i_rddata_A(rda), .i_rddata_B(rdb), .o_rdaddr_A(ra), .o_rdaddr_B(rb), .o_rden(rden),
      .o_capdata_A(capa), .o_capdata_B(capb), .o_memval(memval), .o_STATE(st), .o_busy(busy));

   always #5 clk = ~clk;

   // data for a read strobed in cycle t is valid only during cycle t+RDL
   always @(posedge clk) begin
      pv[0] <= rden;
      pa[0] <= ra;
      pb[0] <= rb;
      junk_a <= 16'($urandom);
      junk_b <= 16'($urandom);
      for (int i = 1; i < RDL; i++) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end
   assign rda = pv[RDL-1] ? mem[pa[RDL-1]] : junk_a;
   assign rdb = pv[RDL-1] ? mem[pb[RDL-1]] : junk_b;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // event recorder: reads with their preceding SHOW length, captures with their latency
   always @(negedge clk) begin
      cyc++;
      if (rst_n && mon_en) begin
         chk("memval", memval, st == 4'h4);
         chk("busy", busy, st != 4'h0 && st != 4'h4);
         chk("state_legal", st <= 4'h4, 1'b1);
         if ({capa, capb} !== prev_cap) chk("cap_edge", prev_st, 4'h3);
         if (rden) begin
            rq.push_back({ra, rb});
            sq.push_back(show_cnt);
            rden_cyc = cyc;
         end
         if (st == 4'h4 && prev_st != 4'h4) begin
            cq.push_back({capa, capb});
            lq.push_back(cyc - rden_cyc);
         end
         show_cnt = (st == 4'h4) ? show_cnt + 1 : 0;
      end else show_cnt = 0;
      prev_st  = st;
      prev_cap = {capa, capb};
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_state", st, 4'h0);
      chk("rst_addr_A", ra, 0);
      chk("rst_addr_B", rb, 16);
      chk("rst_rden", rden, 0);
      chk("rst_capA", capa, 0);
      chk("rst_capB", capb, 0);
      chk("rst_memval", memval, 0);
      chk("rst_busy", busy, 0);
   endtask

   task automatic expect_reads(int n, int show_len);
      logic [9:0] e;
      logic [31:0] c;
      for (int k = 0; k < n; k++) begin
         if (!from_idle) a_m = (a_m + 1) % 16;
         from_idle = 0;
         chk("read_present", rq.size() > 0, 1'b1);
         if (rq.size() > 0) begin
            e = rq.pop_front();
            chk("rdaddr_A", e[9:5], a_m);
            chk("rdaddr_B", e[4:0], a_m + 16);
            if (show_len >= 0) chk("dwell_len", sq.pop_front(), show_len);
            else void'(sq.pop_front());
         end
         chk("capture_present", cq.size() > 0, 1'b1);
         if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("capA", c[31:16], mem[a_m]);
            chk("capB", c[15:0], mem[a_m + 16]);
            chk("cap_latency", lq.pop_front(), RDL + 1);
         end
      end
   endtask

   task automatic wait_caps(int n, int budget);
      int t = 0;
      while (cq.size() < n && t < budget) begin
         tick(1);
         t++;
      end
      chk("cap_timeout", cq.size() >= n, 1'b1);
   endtask

   // bounce segments never reach 4 stable cycles, so each press is exactly one step
   task automatic press(bit bouncy, int hold);
      if (bouncy) repeat ($urandom_range(1, 3)) begin
         step_n = 1'b0;
         tick($urandom_range(1, 3));
         step_n = 1'b1;
         tick($urandom_range(1, 3));
      end
      step_n = 1'b0;
      tick(hold);
      if (bouncy) repeat ($urandom_range(1, 3)) begin
         step_n = 1'b1;
         tick($urandom_range(1, 3));
         step_n = 1'b0;
         tick($urandom_range(1, 3));
      end
      step_n = 1'b1;
      tick(14);
   endtask

   task automatic manual(bit bouncy, int hold);
      press(bouncy, hold);
      chk("one_read", rq.size(), 1);
      expect_reads(1, -1);
      chk("in_show", st, 4'h4);
   endtask

   task automatic align_capture();
      int t = 0;
      while (st != 4'h3 && t < 20) begin
         tick(1);
         t++;
      end
      chk("align", st, 4'h3);
   endtask

   initial begin
      int t;
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      mem[0]  = 16'h00AB;
      mem[16] = 16'h00CD;
      tick(3);
      check_reset_vals();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick(3);
      chk("idle_quiet", st, 4'h0);
      manual(1'b0, 10);
      chk("first_capA", capa, 16'h00AB);
      chk("first_capB", capb, 16'h00CD);
      chk("first_memval", memval, 1'b1);
      step_n = 1'b0; tick(2); step_n = 1'b1; tick(1);
      step_n = 1'b0; tick(2); step_n = 1'b1; tick(1);
      step_n = 1'b0;
      tick(4);
      chk("no_early_step", rq.size(), 0);
      tick(10);
      step_n = 1'b1;
      tick(14);
      chk("bounce_one_read", rq.size(), 1);
      expect_reads(1, -1);
      for (int k = 0; k < 14; k++) manual(1'($urandom_range(0, 1)), $urandom_range(8, 16));
      chk("addr_A_15", ra, 15);
      chk("addr_B_31", rb, 31);
      manual(1'b0, 10);
      chk("wrap_A", ra, 0);
      chk("wrap_B", rb, 16);
      auto_en = 1'b1;
      wait_caps(1, 40);
      expect_reads(1, -1);
      wait_caps(3, 60);
      expect_reads(3, 8);
      // press lands its step pulse (sync 2 + debounce 4) in the following WAIT
      align_capture();
      tick(4);
      step_n = 1'b0;
      tick(10);
      step_n = 1'b1;
      wait_caps(3, 60);
      expect_reads(3, 8);
      // press lands its step pulse on the last SHOW cycle, together with dwell expiry
      align_capture();
      tick(2);
      step_n = 1'b0;
      tick(10);
      step_n = 1'b1;
      wait_caps(3, 60);
      expect_reads(3, -1);
      align_capture();
      auto_en = 1'b0;
      tick(15);
      chk("auto_stop", rq.size(), 1);
      expect_reads(1, -1);
      chk("auto_stop_show", st, 4'h4);
      rst_n = 1'b0;
      tick(2);
      check_reset_vals();
      rq.delete(); sq.delete(); cq.delete(); lq.delete();
      rst_n = 1'b1;
      a_m = 0;
      from_idle = 1;
      tick(2);
      for (int k = 0; k < 5; k++) manual(1'b0, 10);
      step_n = 1'b0;
      t = 0;
      while (st != 4'h2 && t < 30) begin
         tick(1);
         t++;
      end
      chk("reach_wait", st, 4'h2);
      chk("wait_addr", ra, 5);
      #2 rst_n = 1'b0;
      #1 check_reset_vals();
      step_n = 1'b1;
      tick(4);
      check_reset_vals();
      rq.delete(); sq.delete(); cq.delete(); lq.delete();
      rst_n = 1'b1;
      tick(10);
      chk("post_rst_idle", st, 4'h0);
      chk("post_rst_capA", capa, 0);
      chk("post_rst_capB", capb, 0);
      chk("post_rst_no_read", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/debug_mem_stepper.md
DEBUG_MEM_STEPPER -- requirements
Module: debug_mem_stepper

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of each memory data word.
REQ-002 Parameter MEM_SIZE, default 32: memory depth in words; SHALL be a power of two and at least 2.
REQ-003 Parameter ADDR_SIZE, default $clog2(MEM_SIZE): address width.
REQ-004 Parameter RD_LATENCY, default 2: cycles from read-enable to valid read data; SHALL be at least 1.
REQ-005 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a button level change.
REQ-006 Parameter AUTO_DWELL, default 64: cycles spent in SHOW before an automatic advance.
REQ-007 i_CLK  in  1  single clock; all state changes on its rising edge.
REQ-008 i_RST_n  in  1  reset, asynchronous and active-low.
REQ-009 i_step_n  in  1  raw active-low pushbutton; asynchronous to i_CLK and bouncing.
REQ-010 i_auto  in  1  free-run enable; sampled only in SHOW.
REQ-011 i_rddata_A / i_rddata_B  in  WORD_SIZE each  memory read data for ports A and B.
REQ-012 o_rdaddr_A / o_rdaddr_B  out  ADDR_SIZE each  memory read addresses.
REQ-013 o_rden  out  1  read strobe for both memory ports.
REQ-014 o_capdata_A / o_capdata_B  out  WORD_SIZE each  captured read data, held stable for display.
REQ-015 o_memval  out  1  display select: 0 = show addresses, 1 = show captured data.
REQ-016 o_STATE  out  4  current FSM state code.
REQ-017 o_busy  out  1  high in every state except IDLE and SHOW.

Function
REQ-018 i_step_n SHALL pass through a two-flop synchronizer before any other use.
REQ-019 The debouncer SHALL change its accepted level only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any earlier return restarts the count.
REQ-020 A one-cycle step pulse SHALL be generated on each high-to-low transition of the accepted level.
REQ-021 FSM states and o_STATE codes: IDLE=4'h0, REQ=4'h1, WAIT=4'h2, CAPTURE=4'h3, SHOW=4'h4; unused codes SHALL return to IDLE.
REQ-022 IDLE: on a step pulse, go to REQ without changing the address.
REQ-023 REQ lasts one cycle: o_rden=1 in REQ only; next state is WAIT if RD_LATENCY>1, otherwise CAPTURE.
REQ-024 WAIT lasts exactly RD_LATENCY-1 cycles, then goes to CAPTURE.
REQ-025 CAPTURE lasts one cycle: i_rddata_A/B sampled into o_capdata_A/B at its closing edge (RD_LATENCY cycles after the REQ cycle); next state is SHOW.
REQ-026 SHOW leaves on a step pulse, or on dwell-counter expiry (AUTO_DWELL cycles in SHOW) when i_auto=1; the exit edge increments the address and enters REQ.
REQ-027 If a step pulse and dwell expiry coincide, exactly one advance SHALL occur.
REQ-028 Step pulses arriving in REQ, WAIT or CAPTURE SHALL be discarded, not queued.
REQ-029 o_rdaddr_A counts 0..MEM_SIZE/2-1 and wraps to 0; o_rdaddr_B = o_rdaddr_A + MEM_SIZE/2 (butterfly pair); the addition SHALL be modulo 2^ADDR_SIZE.
REQ-030 o_memval=1 in SHOW only; 0 in all other states.
REQ-031 o_capdata_A/B SHALL change only at the CAPTURE edge.
REQ-032 The dwell counter SHALL clear on every entry to SHOW.

Reset
REQ-033 While i_RST_n=0, SHALL force: state IDLE, o_STATE=4'h0, o_rdaddr_A=0, o_rdaddr_B=MEM_SIZE/2, o_rden=0, o_capdata_A/B=0, o_memval=0, o_busy=0, debouncer accepted level high, synchronizer high, dwell counter 0.
REQ-034 A reset asserted in any state, including mid-read, SHALL abort the read, and no capture SHALL occur.

Verification (DEBOUNCE_CYCLES=4, RD_LATENCY=2, MEM_SIZE=32)
REQ-035 Reset release, then a clean press of 10 cycles -> exactly one o_rden pulse, o_rdaddr_A=0, o_rdaddr_B=16; data 16'h00AB/16'h00CD presented 2 cycles later -> captured; SHOW, o_memval=1.
REQ-036 Bouncing press (low 2, high 1, low 2, high 1 cycles), then held low -> no step until 4 stable low cycles; exactly one step for the whole press.
REQ-037 15 steps from SHOW at A=0 -> A=15, B=31; next step -> A=0, B=16.
REQ-038 i_auto=1 with AUTO_DWELL=8 -> advance every 8 SHOW cycles; press during WAIT -> ignored, address advances by 1 only.
REQ-039 Reset asserted in WAIT with A=5 -> all outputs return immediately to REQ-033 values; o_capdata unchanged from 0.
